// File: rtl/counter_monitor_if.sv
// Observed-counter snoop signals and monitor status outputs.
// The master drives the snooped counter signals and the slave is the monitor.
interface counter_monitor_if #(
    parameter int unsigned WIDTH     = 4,
    parameter int unsigned ERR_CNT_W = 8
);
    logic                 cnt_reset;
    logic                 cnt_enable;
    logic [WIDTH-1:0]     cnt_value;
    logic                 clear_err;
    logic                 mismatch;
    logic                 err_sticky;
    logic [ERR_CNT_W-1:0] err_count;
    logic [WIDTH-1:0]     expected;
    logic                 locked;

    modport master (
        output cnt_reset, cnt_enable, cnt_value, clear_err,
        input  mismatch, err_sticky, err_count, expected, locked
    );

    modport slave (
        input  cnt_reset, cnt_enable, cnt_value, clear_err,
        output mismatch, err_sticky, err_count, expected, locked
    );
endinterface

// File: rtl/counter_monitor.sv
// In-circuit checker for an enable/sync-reset up-counter: reference model, compare, error stats.
// Define COUNTER_MONITOR_RESYNC_EN to reload the reference on a failure instead of entering FAULT.
module counter_monitor #(
    parameter int unsigned WIDTH     = 4,
    parameter int unsigned ERR_CNT_W = 8
) (
    input  logic           clk,
    input  logic           reset_n,
    counter_monitor_if.slave bus
);

    typedef enum logic [1:0] {StUnsync, StTrack, StFault} state_e;

    state_e               state_q, state_d;
    logic [WIDTH-1:0]     expected_q, expected_d;
    logic                 mismatch_q, mismatch_d;
    logic                 err_sticky_q, err_sticky_d;
    logic [ERR_CNT_W-1:0] err_count_q, err_count_d;
    logic                 locked_q, locked_d;
    logic                 fail;

    always_comb begin
        fail = (state_q == StTrack) && (bus.cnt_value != expected_q);

        if (bus.cnt_reset) begin
            expected_d = '0;
        end else if (bus.cnt_enable) begin
            expected_d = expected_q + WIDTH'(1);
        end else begin
            expected_d = expected_q;
        end

        state_d = state_q;
        unique case (state_q)
            StUnsync: if (bus.cnt_reset) state_d = StTrack;
            StTrack: begin
`ifdef COUNTER_MONITOR_RESYNC_EN
                // Realign to the observed counter and keep checking from the next edge.
                if (fail) begin
                    expected_d = bus.cnt_reset ? '0 :
                                 bus.cnt_value + WIDTH'(bus.cnt_enable);
                end
`else
                if (fail) state_d = StFault;
`endif
            end
            StFault: begin
                if (bus.cnt_reset) begin
                    state_d = StTrack;
                end else if (bus.clear_err) begin
                    state_d = StUnsync;
                end
            end
            default: state_d = StUnsync;
        endcase

        mismatch_d   = fail;
        err_sticky_d = err_sticky_q;
        err_count_d  = err_count_q;
        // A failure on the same edge as clear_err wins and counts as the first error.
        if (fail) begin
            err_sticky_d = 1'b1;
            if (bus.clear_err) begin
                err_count_d = ERR_CNT_W'(1);
            end else if (err_count_q != '1) begin
                err_count_d = err_count_q + ERR_CNT_W'(1);
            end
        end else if (bus.clear_err) begin
            err_sticky_d = 1'b0;
            err_count_d  = '0;
        end

        locked_d = (state_d == StTrack);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= StUnsync;
            expected_q   <= '0;
            mismatch_q   <= 1'b0;
            err_sticky_q <= 1'b0;
            err_count_q  <= '0;
            locked_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            expected_q   <= expected_d;
            mismatch_q   <= mismatch_d;
            err_sticky_q <= err_sticky_d;
            err_count_q  <= err_count_d;
            locked_q     <= locked_d;
        end
    end

    assign bus.mismatch   = mismatch_q;
    assign bus.err_sticky = err_sticky_q;
    assign bus.err_count  = err_count_q;
    assign bus.expected   = expected_q;
    assign bus.locked     = locked_q;

endmodule
